// File: rtl/ecc_point_add_if.sv
// Operand/result bus of the elliptic-curve point-addition engine.
// in_valid is a one-cycle strobe with all in_* fields valid alongside it; there is no ready,
// strobes outside IDLE are dropped. out_valid is a one-cycle strobe with out_rx/out_ry valid alongside it.
interface ecc_point_add_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic [WIDTH-1:0] in_xp;
  logic [WIDTH-1:0] in_yp;
  logic [WIDTH-1:0] in_xq;
  logic [WIDTH-1:0] in_yq;
  logic [WIDTH-1:0] in_prime;
  logic [WIDTH-1:0] in_a;
  logic             out_valid;
  logic [WIDTH-1:0] out_rx;
  logic [WIDTH-1:0] out_ry;

  modport master (
    output in_valid, in_xp, in_yp, in_xq, in_yq, in_prime, in_a,
    input  out_valid, out_rx, out_ry
  );

  modport slave (
    input  in_valid, in_xp, in_yp, in_xq, in_yq, in_prime, in_a,
    output out_valid, out_rx, out_ry
  );
endinterface

// File: rtl/ecc_point_add.sv
// Sequential R = P + Q over GF(p) on y^2 = x^3 + a*x + b, with doubling when P == Q.
// The slope denominator is inverted by a combinational modular-inverse block in a single cycle.
module mod_inv #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] IN_1,
  input  logic [WIDTH-1:0] IN_2,
  output logic [WIDTH-1:0] OUT_1
);
  logic [2*WIDTH-1:0] prod;
  logic               found;

  // The first (smallest) candidate whose product is 1 mod p is always below p.
  always_comb begin
    OUT_1 = '0;
    found = 1'b0;
    prod  = '0;
    for (int i = 1; i < (1 << WIDTH); i++) begin
      prod = ({{WIDTH{1'b0}}, IN_2} * (2*WIDTH)'(i)) % {{WIDTH{1'b0}}, IN_1};
      if (!found && prod == (2*WIDTH)'(1)) begin
        OUT_1 = WIDTH'(i);
        found = 1'b1;
      end
    end
  end
endmodule

module ecc_point_add #(
  parameter int WIDTH = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  ecc_point_add_if.slave bus,
  output logic [2:0]   dbg_state
);
  localparam int WW = 2*WIDTH + 2;

  typedef enum logic [2:0] {IDLE, DEN, INV, LAM, XR, YR, OUT} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] xp, yp, xq, yq, p, a;
  logic [WIDTH-1:0] num, den, inv, lam, xr, yr;
  logic [WIDTH-1:0] num_c, den_c, inv_c, lam_c, xr_c, yr_c;
  logic [WW-1:0]    xp_w, yp_w, xq_w, yq_w, p_w, a_w, num_w, inv_w, lam_w, xr_w;
  logic             dbl;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = DEN;
      DEN:     state_nxt = INV;
      INV:     state_nxt = LAM;
      LAM:     state_nxt = XR;
      XR:      state_nxt = YR;
      YR:      state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Widen everything up front; every subtraction adds p (or 2p) first so nothing underflows.
  assign xp_w  = WW'(xp);
  assign yp_w  = WW'(yp);
  assign xq_w  = WW'(xq);
  assign yq_w  = WW'(yq);
  assign p_w   = WW'(p);
  assign a_w   = WW'(a);
  assign num_w = WW'(num);
  assign inv_w = WW'(inv);
  assign lam_w = WW'(lam);
  assign xr_w  = WW'(xr);

  assign dbl   = (xp == xq) && (yp == yq);
  assign num_c = dbl ? WIDTH'((WW'(3) * xp_w * xp_w + a_w) % p_w)
                     : WIDTH'((yq_w + p_w - yp_w) % p_w);
  assign den_c = dbl ? WIDTH'((yp_w + yp_w) % p_w)
                     : WIDTH'((xq_w + p_w - xp_w) % p_w);
  assign lam_c = WIDTH'((num_w * inv_w) % p_w);
  assign xr_c  = WIDTH'((lam_w * lam_w + p_w + p_w - xp_w - xq_w) % p_w);
  assign yr_c  = WIDTH'((lam_w * (xp_w + p_w - xr_w) + p_w - yp_w) % p_w);

  mod_inv #(.WIDTH(WIDTH)) u_inv (
    .IN_1  (p),
    .IN_2  (den),
    .OUT_1 (inv_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xp <= '0; yp <= '0; xq <= '0; yq <= '0; p <= '0; a <= '0;
      num <= '0; den <= '0; inv <= '0; lam <= '0; xr <= '0; yr <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          xp <= bus.in_xp;
          yp <= bus.in_yp;
          xq <= bus.in_xq;
          yq <= bus.in_yq;
          p  <= bus.in_prime;
          a  <= bus.in_a;
        end
        DEN: begin
          num <= num_c;
          den <= den_c;
        end
        INV:     inv <= inv_c;
        LAM:     lam <= lam_c;
        XR:      xr  <= xr_c;
        YR:      yr  <= yr_c;
        default: ;
      endcase
    end
  end

  // Result is registered out of OUT, so the strobe lands in the following (IDLE) cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_rx    <= '0;
      bus.out_ry    <= '0;
    end else begin
      bus.out_valid <= (state == OUT);
      bus.out_rx    <= (state == OUT) ? xr : '0;
      bus.out_ry    <= (state == OUT) ? yr : '0;
    end
  end
endmodule
